hm_link_sched: RTL and testbench
================================

Name: hm_link_sched

Overview:
- Controller and scheduler for the serial leg of the Hamming (7,4) link.
- Accepts 7-bit codewords from the encoder through a valid/ready handshake.
- Sequences them MSB-first onto the serial channel, with framed idle gaps between words.
- Independently re-assembles received serial bits into 7-bit words for the decoder, with a one-cycle strobe and a running word count.

Parameters:
- CW_W, 7: codeword width in bits (serial bits per word).
- GAP, 1: idle cycles inserted after each transmitted word (0 allowed).
- CNT_W, 16: width of the received-word counter.

Ports:
- clk16  in  1  bit clock; one serial bit per cycle.
- rst  in  1  synchronous, active-high reset.
- cw_in  in  CW_W  codeword from encoder.
- cw_valid  in  1  cw_in valid.
- cw_ready  out  1  scheduler can accept a word.
- noise_en  in  1  request noise injection on the word being accepted (used only with the optional feature).
- ser_out  out  1  serial TX bit.
- ser_valid  out  1  ser_out carries a codeword bit.
- ser_in  in  1  serial RX bit (after the noise channel).
- ser_in_valid  in  1  ser_in carries a bit.
- par_out  out  CW_W  assembled received codeword.
- par_valid  out  1  one-cycle strobe; par_out is new.
- word_cnt  out  CNT_W  number of received words, wraps.
- busy  out  1  TX FSM not in IDLE.

Behaviour:
- Clocking and reset: single clock clk16; rst is synchronous and active-high.
- While rst is high, all outputs are 0, including cw_ready. All counters and shift registers clear.
- TX FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - cw_ready=1.
  - On cw_valid & cw_ready at edge N: load shift register with cw_in, latch noise_en, bit counter=0, go to SHIFT.
- SHIFT:
  - ser_valid=1 and ser_out = current MSB, starting in the cycle after N (latency 1).
  - Exactly CW_W cycles, bit CW_W-1 first, bit 0 last.
  - After the last bit: go to GAP if GAP>0, else IDLE.
- GAP: ser_valid=0, ser_out=0 for exactly GAP cycles, then IDLE.
- cw_ready is 0 in SHIFT and GAP. cw_valid is ignored there; the upstream must hold the word.
- Back-to-back throughput: one word per CW_W+GAP+1 cycles.
- busy=1 in SHIFT and GAP.
- RX path is independent of the TX FSM.
  - Each cycle with ser_in_valid=1 stores ser_in at position CW_W-1-k, where k is the RX bit index (0..CW_W-1).
  - On the cycle the CW_W-th bit is sampled, the full word, including that last bit, is transferred to par_out at the same edge.
  - par_valid=1 for exactly the following cycle; k returns to 0.
  - ser_in_valid=0 holds the partial word indefinitely; there is no timeout.
  - par_out holds its value until the next completed word.
- word_cnt increments on each par_valid and wraps from 2^CNT_W-1 to 0.
- Simultaneous TX acceptance and RX completion are both serviced in the same cycle.
- Reset mid-word: the TX word is dropped and ser_valid is 0 after the rst edge. The RX partial word is discarded and the next bit starts at k=0.

Optional Feature:
- Macro HM_NOISE_INJ_EN.
- When defined:
  - If noise_en was latched high at acceptance, exactly one bit of that word is inverted on ser_out.
  - The inverted bit is at position noise_pos.
  - noise_pos resets to CW_W-1, decrements after each injected word, and wraps 0 -> CW_W-1.
  - Words accepted with noise_en=0 pass unmodified and do not advance noise_pos.
- When undefined: noise_en is ignored, ser_out is always the exact codeword, and the noise_pos logic is absent.

Decomposition:
- Package hm_pkg: CW_W=7 and DATA_W=4 constants, plus tx_state_t enum {IDLE, SHIFT, GAP}.
- One sub-module is natural: hm_deser7, the RX bit assembly, par strobe and word_cnt logic. The top holds the TX FSM and noise injection.

Test Plan:
- Reset, then cw_in=7'b1011010 with cw_valid held 1 cycle -> ser_out over cycles 1..7 = 1,0,1,1,0,1,0, ser_valid=1 for 7 cycles, cw_ready low for 7+GAP cycles.
- Loop ser_out to ser_in, ser_valid to ser_in_valid, stream 0x55, 0x2A, 0x7F -> par_out equals each word, par_valid is a single pulse 1 cycle after the last bit, word_cnt=3.
- ser_in_valid toggled every other cycle while sending 7'b1100110 -> par_out=7'b1100110 after the 7th valid bit; no strobe earlier.
- rst asserted after 3 TX bits and 3 RX bits, then a fresh word 7'b0000001 -> ser_valid drops at the rst edge, and the next par_out=7'b0000001, not mixed with stale bits.
- CNT_W=3, send 9 words -> word_cnt sequence 1..7, 0, 1.
- HM_NOISE_INJ_EN defined, noise_en=1, send 7'b0000000 three times -> received 7'b1000000, 7'b0100000, 7'b0010000; with noise_en=0 -> 7'b0000000.

Source files
------------

// File: rtl/hm_pkg.sv
// Shared constants and TX state encoding for the Hamming (7,4) serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hm_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/hm_deser7.sv
// RX word assembly: packs serial bits MSB-first into a codeword, strobes it and counts words.
// Latency: par_out/par_valid/word_cnt update at the edge that samples the last bit.
// Backpressure: none; ser_in_valid low simply holds the partial word indefinitely.
module hm_deser7 #(
    parameter int CW_W  = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk16,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    output logic [CW_W-1:0]  par_out,
    output logic             par_valid,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int             K_W    = $clog2(CW_W);
    localparam logic [K_W-1:0] K_LAST = K_W'(CW_W - 1);

    logic [K_W-1:0]   k_q;
    logic [CW_W-1:0]  acc_q;
    logic [CW_W-1:0]  acc_nxt;
    logic [CW_W-1:0]  par_q;
    logic             pv_q;
    logic [CNT_W-1:0] cnt_q;

    // Partial word with the current bit dropped into its MSB-first slot.
    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[K_LAST - k_q] = ser_in;
    end

    // Bit index, partial word, completed word, strobe and wrapping word counter.
    always_ff @(posedge clk16) begin
        if (rst) begin
            k_q   <= '0;
            acc_q <= '0;
            par_q <= '0;
            pv_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            pv_q <= 1'b0;
            if (ser_in_valid) begin
                if (k_q == K_LAST) begin
                    // Clear the accumulator so no stale bits leak into the next word.
                    k_q   <= '0;
                    acc_q <= '0;
                    par_q <= acc_nxt;
                    pv_q  <= 1'b1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    k_q   <= k_q + K_W'(1);
                    acc_q <= acc_nxt;
                end
            end
        end
    end

    // Outputs read as zero for as long as reset is held.
    assign par_out   = rst ? '0   : par_q;
    assign par_valid = rst ? 1'b0 : pv_q;
    assign word_cnt  = rst ? '0   : cnt_q;

endmodule

// File: rtl/hm_link_sched.sv
// Serial-leg scheduler: serialises codewords MSB-first with idle gaps, and reassembles RX words.
// Latency: first TX bit one cycle after acceptance; one word per CW_W+GAP+1 cycles back-to-back.
// Backpressure: cw_ready low in SHIFT/GAP, upstream holds the word. Optional HM_NOISE_INJ_EN flips one bit per flagged word.
module hm_link_sched import hm_pkg::*; #(
    parameter int CW_W  = hm_pkg::CW_W,
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk16,
    input  logic             rst,
    input  logic [CW_W-1:0]  cw_in,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  logic             noise_en,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    output logic [CW_W-1:0]  par_out,
    output logic             par_valid,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    localparam int               BIT_W    = $clog2(CW_W);
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CW_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [CW_W-1:0]  sr_q;
    logic [BIT_W-1:0] bit_q;
    logic [GAP_W-1:0] gap_q;
    logic             accept;
    logic             last_bit;
    logic             flip;

    assign accept   = cw_valid && (state_q == IDLE);
    assign last_bit = (state_q == SHIFT) && (bit_q == BIT_LAST);

    // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> GAP/IDLE after the last bit, GAP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (cw_valid) state_d = SHIFT;
            SHIFT:       if (bit_q == BIT_LAST) state_d = (GAP > 0) ? hm_pkg::GAP : IDLE;
            hm_pkg::GAP: if (gap_q == GAP_LAST) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // State register plus shift register, bit counter and gap counter.
    always_ff @(posedge clk16) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sr_q  <= cw_in;
                bit_q <= '0;
                gap_q <= '0;
            end else if (state_q == SHIFT) begin
                sr_q  <= {sr_q[CW_W-2:0], 1'b0};
                bit_q <= bit_q + BIT_W'(1);
            end else if (state_q == hm_pkg::GAP) begin
                gap_q <= gap_q + GAP_W'(1);
            end
        end
    end

`ifdef HM_NOISE_INJ_EN
    logic             noise_q;
    logic [BIT_W-1:0] noise_pos_q;

    // Latch the noise request per word; rotate the injected position downward after each noisy word.
    always_ff @(posedge clk16) begin
        if (rst) begin
            noise_q     <= 1'b0;
            noise_pos_q <= BIT_LAST;
        end else begin
            if (accept) begin
                noise_q <= noise_en;
            end
            if (last_bit && noise_q) begin
                noise_pos_q <= (noise_pos_q == '0) ? BIT_LAST : noise_pos_q - BIT_W'(1);
            end
        end
    end

    // Bit index k carries codeword bit CW_W-1-k, so position p goes out at k = CW_W-1-p.
    assign flip = noise_q && (bit_q == (BIT_LAST - noise_pos_q));
`else
    logic unused_noise_en;

    assign unused_noise_en = noise_en;
    assign flip            = 1'b0;
`endif

    // Handshake and serial outputs are forced low while reset is held.
    assign cw_ready  = !rst && (state_q == IDLE);
    assign busy      = !rst && (state_q != IDLE);
    assign ser_valid = !rst && (state_q == SHIFT);
    assign ser_out   = ser_valid && (sr_q[CW_W-1] ^ flip);

    hm_deser7 #(
        .CW_W  (CW_W),
        .CNT_W (CNT_W)
    ) u_deser (
        .clk16        (clk16),
        .rst          (rst),
        .ser_in       (ser_in),
        .ser_in_valid (ser_in_valid),
        .par_out      (par_out),
        .par_valid    (par_valid),
        .word_cnt     (word_cnt)
    );

endmodule

// File: tb/tb_hm_link_sched.sv
// Bench for hm_link_sched: table of loopback words, directed corner sequences, random TX/RX traffic.
// Inputs change on the falling edge; outputs are sampled on the falling edge, RX stream model 2 time units later.
// Build with HM_NOISE_INJ_EN defined to exercise the noise-injection expectations.
module tb_hm_link_sched;

    localparam int TB_GAP = 1;

    logic       clk16;
    logic       rst;
    logic [6:0] cw_in;
    logic       cw_valid;
    logic       cw_ready;
    logic       noise_en;
    logic       ser_out;
    logic       ser_valid;
    logic       si;
    logic       siv;
    logic [6:0] par_out;
    logic       par_valid;
    logic [2:0] word_cnt;
    logic       busy;

    logic       lb;
    logic       rx_bit;
    logic       rx_vld;
    logic       mon_stop;
    int         n_cmp;
    int         n_bad;
    int         model_pos;

    // RX source: either the TX line looped back, or bench-driven bits.
    assign si  = lb ? ser_out   : rx_bit;
    assign siv = lb ? ser_valid : rx_vld;

    hm_link_sched #(
        .CW_W  (7),
        .GAP   (TB_GAP),
        .CNT_W (3)
    ) dut (
        .clk16        (clk16),
        .rst          (rst),
        .cw_in        (cw_in),
        .cw_valid     (cw_valid),
        .cw_ready     (cw_ready),
        .noise_en     (noise_en),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .ser_in       (si),
        .ser_in_valid (siv),
        .par_out      (par_out),
        .par_valid    (par_valid),
        .word_cnt     (word_cnt),
        .busy         (busy)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // RX reference: collect valid bits in a queue; every 7 bits form a word (first bit = MSB).
    logic       exp_pv;
    logic [6:0] exp_par;
    int         exp_cnt;
    bit         rxq[$];

    initial begin
        logic [6:0] w;
        exp_pv  = 1'b0;
        exp_par = '0;
        exp_cnt = 0;
        forever begin
            @(negedge clk16);
            #2;
            if (!mon_stop) begin
                check("rx_par_valid", 32'(par_valid), rst ? 32'd0 : 32'(exp_pv));
                check("rx_par_out",   32'(par_out),   rst ? 32'd0 : 32'(exp_par));
                check("rx_word_cnt",  32'(word_cnt),  rst ? 32'd0 : 32'(exp_cnt));
                if (rst) begin
                    rxq.delete();
                    exp_pv  = 1'b0;
                    exp_par = '0;
                    exp_cnt = 0;
                end else begin
                    exp_pv = 1'b0;
                    if (siv) begin
                        rxq.push_back(si);
                        if (rxq.size() == 7) begin
                            w = '0;
                            for (int i = 0; i < 7; i++) w[6-i] = rxq[i];
                            exp_par = w;
                            exp_pv  = 1'b1;
                            exp_cnt = (exp_cnt + 1) % 8;
                            rxq.delete();
                        end
                    end
                end
            end
        end
    end

    // Send one word and check every TX cycle against the expected bit sequence.
    task automatic tx_word(input logic [6:0] cw, input logic ne);
        logic [6:0] eb;
        int         guard;
        guard = 0;
        while (cw_ready !== 1'b1 && guard < 200) begin
            @(negedge clk16);
            guard++;
        end
        check("tx_ready_wait", 32'(cw_ready), 32'd1);
        eb = cw;
`ifdef HM_NOISE_INJ_EN
        if (ne) begin
            eb[model_pos] = ~eb[model_pos];
            model_pos = (model_pos == 0) ? 6 : model_pos - 1;
        end
`endif
        cw_in    = cw;
        cw_valid = 1'b1;
        noise_en = ne;
        @(negedge clk16);
        cw_valid = 1'b0;
        noise_en = 1'b0;
        cw_in    = 7'($urandom);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk16);
            check("tx_ser_valid", 32'(ser_valid), 32'd1);
            check("tx_ser_out",   32'(ser_out),   32'(eb[6-k]));
            check("tx_cw_ready",  32'(cw_ready),  32'd0);
            check("tx_busy",      32'(busy),      32'd1);
        end
        for (int g = 0; g < TB_GAP; g++) begin
            @(negedge clk16);
            check("gap_ser_valid", 32'(ser_valid), 32'd0);
            check("gap_ser_out",   32'(ser_out),   32'd0);
            check("gap_cw_ready",  32'(cw_ready),  32'd0);
            check("gap_busy",      32'(busy),      32'd1);
        end
        @(negedge clk16);
        check("idle_cw_ready",  32'(cw_ready),  32'd1);
        check("idle_busy",      32'(busy),      32'd0);
        check("idle_ser_valid", 32'(ser_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk16);
        rst      = 1'b1;
        cw_valid = 1'b0;
        rx_vld   = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk16);
            check("rst_cw_ready",  32'(cw_ready),  32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_ser_valid", 32'(ser_valid), 32'd0);
            check("rst_ser_out",   32'(ser_out),   32'd0);
            check("rst_par_valid", 32'(par_valid), 32'd0);
            check("rst_par_out",   32'(par_out),   32'd0);
            check("rst_word_cnt",  32'(word_cnt),  32'd0);
        end
        rst       = 1'b0;
        model_pos = 6;
        @(negedge clk16);
        check("post_rst_cw_ready", 32'(cw_ready), 32'd1);
        check("post_rst_busy",     32'(busy),     32'd0);
    endtask

    typedef struct {
        logic [6:0] cw;
        logic       ne;
        logic [6:0] exp_plain;
        logic [6:0] exp_noisy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] w;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; cw_in = '0; cw_valid = 1'b0; noise_en = 1'b0;
        rx_bit = 1'b0; rx_vld = 1'b0; lb = 1'b0; model_pos = 6; mon_stop = 1'b0;

        tbl[0] = '{7'h55,      1'b0, 7'h55,      7'h55};
        tbl[1] = '{7'h2A,      1'b0, 7'h2A,      7'h2A};
        tbl[2] = '{7'h7F,      1'b0, 7'h7F,      7'h7F};
        tbl[3] = '{7'b0000000, 1'b1, 7'b0000000, 7'b1000000};
        tbl[4] = '{7'b0000000, 1'b1, 7'b0000000, 7'b0100000};
        tbl[5] = '{7'b0000000, 1'b1, 7'b0000000, 7'b0010000};
        tbl[6] = '{7'b0000000, 1'b0, 7'b0000000, 7'b0000000};
        tbl[7] = '{7'b1011010, 1'b0, 7'b1011010, 7'b1011010};
        tbl[8] = '{7'b0001111, 1'b1, 7'b0001111, 7'b0000111};

        do_reset();

        // Directed TX word with RX idle: bits 1,0,1,1,0,1,0 then gap.
        tx_word(7'b1011010, 1'b0);

        // Loopback table.
        lb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_word(tbl[i].cw, tbl[i].ne);
`ifdef HM_NOISE_INJ_EN
            check("tbl_par_out", 32'(par_out), 32'(tbl[i].exp_noisy));
`else
            check("tbl_par_out", 32'(par_out), 32'(tbl[i].exp_plain));
`endif
            if (i == 2) check("tbl_word_cnt3", 32'(word_cnt), 32'd3);
        end
        lb = 1'b0;

        // RX valid on every other cycle.
        w = 7'b1100110;
        for (int i = 0; i < 14; i++) begin
            rx_vld = (i % 2 == 0);
            rx_bit = rx_vld ? w[6 - i/2] : 1'($urandom);
            @(negedge clk16);
        end
        rx_vld = 1'b0;
        repeat (2) @(negedge clk16);
        check("toggle_par_out", 32'(par_out), 32'(w));

        // RX completion on the same edge as TX acceptance.
        w = 7'b0110011;
        for (int i = 0; i < 6; i++) begin
            rx_vld = 1'b1;
            rx_bit = w[6-i];
            @(negedge clk16);
        end
        fork
            tx_word(7'b1100001, 1'b0);
            begin
                rx_vld = 1'b1;
                rx_bit = w[0];
                @(negedge clk16);
                rx_vld = 1'b0;
            end
        join
        check("simul_par_out", 32'(par_out), 32'(w));

        // Random TX words alongside an independent random RX stream.
        fork
            for (int j = 0; j < 12; j++) tx_word(7'($urandom), 1'($urandom));
            for (int c = 0; c < 140; c++) begin
                rx_vld = ($urandom % 3) != 0;
                rx_bit = 1'($urandom);
                @(negedge clk16);
            end
        join
        rx_vld = 1'b0;
        @(negedge clk16);

        // Reset after 3 TX bits / 3 RX bits, then a fresh word must arrive clean.
        lb = 1'b1;
        cw_in = 7'b1111111;
        cw_valid = 1'b1;
        @(negedge clk16);
        cw_valid = 1'b0;
        repeat (3) @(negedge clk16);
        check("midrst_ser_valid_before", 32'(ser_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ser_valid_rst", 32'(ser_valid), 32'd0);
        @(negedge clk16);
        check("midrst_ser_valid_after", 32'(ser_valid), 32'd0);
        check("midrst_busy_after",      32'(busy),      32'd0);
        rst = 1'b0;
        model_pos = 6;
        tx_word(7'b0000001, 1'b0);
        check("midrst_par_out",  32'(par_out),  32'd1);
        check("midrst_word_cnt", 32'(word_cnt), 32'd1);

        // Counter wrap with a 3-bit word_cnt: 1..7, 0, 1.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tx_word(7'($urandom), 1'b0);
            check("wrap_word_cnt", 32'(word_cnt), 32'((i + 1) % 8));
        end
        lb = 1'b0;

        mon_stop = 1'b1;
        @(negedge clk16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
